instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_isa_pkg.sv | 34 +++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode constants as stored in the instruction RAM,
// the fetch FSM state encoding and the operand-word decode.
package cpu_isa_pkg;

    localparam logic [15:0] OP_LDAC  = 16'd5;
    localparam logic [15:0] OP_STAC  = 16'd7;
    localparam logic [15:0] OP_LDA   = 16'd9;
    localparam logic [15:0] OP_LDB   = 16'd14;
    localparam logic [15:0] OP_LDC   = 16'd19;
    localparam logic [15:0] OP_STC   = 16'd24;
    localparam logic [15:0] OP_JUMP  = 16'd46;
    localparam logic [15:0] OP_JPNZ  = 16'd48;
    localparam logic [15:0] OP_ENDOP = 16'd51;

    typedef enum logic [2:0] {
        FETCH,
        CAPT_OP,
        CAPT_ARG,
        VALID,
        HALT
    } fetch_state_t;

    // True when the opcode is followed by an operand word in memory.
    function automatic logic has_operand(input logic [15:0] opcode);
        logic result;
        case (opcode)
            OP_LDAC, OP_STAC, OP_LDA, OP_LDB,
            OP_LDC, OP_STC, OP_JUMP, OP_JPNZ: result = 1'b1;
            default:                          result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one- or two-word instructions from a RAM with
// one cycle of read latency and presents them to the control unit through a
// valid/ready handshake. Redirects (taken jumps) restart fetch at a new PC;
// ENDOP stops fetch until a redirect or reset.
// Optional feature: define IFETCH_COUNT_EN to add the ins_count output, a
// 16-bit count of accepted instructions.
module instr_fetch
    import cpu_isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] iram_addr,
    input  logic [15:0] iram_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_opcode,
    output logic [15:0] ins_operand,
    output logic        ins_has_operand,
    output logic [15:0] ins_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
`ifdef IFETCH_COUNT_EN
    output logic [15:0] ins_count,
`endif
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_step;
    logic         handshake;

    assign handshake = (state == VALID) && ins_ready;
    assign pc_step   = ins_has_operand ? 16'd2 : 16'd1;

    // Status flags decode straight from the registered state.
    assign ins_valid = (state == VALID);
    assign halted    = (state == HALT);

    // RAM address: the opcode address, moving to pc+1 only once the captured
    // opcode turns out to need an operand word; otherwise it holds.
    always_comb begin
        // NOTE: every path must assign iram_addr; the default up front keeps this block free of latches.
        iram_addr = pc;
        case (state)
            CAPT_OP:  if (has_operand(iram_data)) iram_addr = pc + 16'd1;
            CAPT_ARG: iram_addr = pc + 16'd1;
            VALID:    if (ins_has_operand) iram_addr = pc + 16'd1;
            default:  iram_addr = pc;
        endcase
    end

    // Fetch FSM: reset beats redirect, redirect beats normal sequencing.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            ins_opcode      <= 16'd0;
            ins_operand     <= 16'd0;
            ins_has_operand <= 1'b0;
            ins_pc          <= 16'd0;
        end else if (redirect_valid) begin
            pc    <= redirect_addr;
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    state <= CAPT_OP;
                end
                CAPT_OP: begin
                    ins_opcode      <= iram_data;
                    ins_pc          <= pc;
                    ins_operand     <= 16'd0;
                    ins_has_operand <= has_operand(iram_data);
                    state           <= has_operand(iram_data) ? CAPT_ARG : VALID;
                end
                CAPT_ARG: begin
                    ins_operand <= iram_data;
                    state       <= VALID;
                end
                VALID: begin
                    if (ins_ready) begin
                        pc    <= pc + pc_step;
                        state <= (ins_opcode == OP_ENDOP) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef IFETCH_COUNT_EN
    // Accepted-instruction counter; a handshake coinciding with a redirect still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_count <= 16'd0;
        end else if (handshake) begin
            ins_count <= ins_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: basic fetch, backpressure, back-to-back,
// redirect, halt, reset mid-operand and PC wrap (second instance).
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] iram_addr;
    logic [15:0] iram_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_opcode;
    logic [15:0] ins_operand;
    logic        ins_has_operand;
    logic [15:0] ins_pc;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halted;

    logic        rst_w;
    logic [15:0] iram_addr_w;
    logic [15:0] iram_data_w;
    logic        ins_valid_w;
    logic        ins_ready_w;
    logic [15:0] ins_opcode_w;
    logic [15:0] ins_operand_w;
    logic        ins_has_operand_w;
    logic [15:0] ins_pc_w;
    logic        redirect_valid_w;
    logic [15:0] redirect_addr_w;
    logic        halted_w;

`ifdef IFETCH_COUNT_EN
    logic [15:0] ins_count;
    logic [15:0] ins_count_w;
    logic [15:0] hs_count;
`endif

    logic [15:0] ram [0:65535];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;

    instr_fetch #(.RESET_PC(16'd0)) dut (
        .clk             (clk),
        .rst             (rst),
        .iram_addr       (iram_addr),
        .iram_data       (iram_data),
        .ins_valid       (ins_valid),
        .ins_ready       (ins_ready),
        .ins_opcode      (ins_opcode),
        .ins_operand     (ins_operand),
        .ins_has_operand (ins_has_operand),
        .ins_pc          (ins_pc),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
`ifdef IFETCH_COUNT_EN
        .ins_count       (ins_count),
`endif
        .halted          (halted)
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) dut_w (
        .clk             (clk),
        .rst             (rst_w),
        .iram_addr       (iram_addr_w),
        .iram_data       (iram_data_w),
        .ins_valid       (ins_valid_w),
        .ins_ready       (ins_ready_w),
        .ins_opcode      (ins_opcode_w),
        .ins_operand     (ins_operand_w),
        .ins_has_operand (ins_has_operand_w),
        .ins_pc          (ins_pc_w),
        .redirect_valid  (redirect_valid_w),
        .redirect_addr   (redirect_addr_w),
`ifdef IFETCH_COUNT_EN
        .ins_count       (ins_count_w),
`endif
        .halted          (halted_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction RAMs with one cycle of read latency.
    always @(posedge clk) iram_data <= ram[iram_addr];
    always @(posedge clk) begin
        case (iram_addr_w)
            16'hFFFF: iram_data_w <= 16'd5;
            16'h0000: iram_data_w <= 16'd4;
            16'h0001: iram_data_w <= 16'd51;
            default:  iram_data_w <= 16'd0;
        endcase
    end

`ifdef IFETCH_COUNT_EN
    // Independent handshake tally for the main instance.
    always @(posedge clk) begin
        if (rst) hs_count <= 16'd0;
        else if (ins_valid && ins_ready) hs_count <= hs_count + 16'd1;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until ins_valid, at most 10 cycles; n returns cycles taken.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!ins_valid && cycles < 10);
    endtask

    task automatic test_reset();
        rst = 1'b1; ins_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = 16'd0;
        step(); step();
        n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", ins_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
        n_cmp++; if (ins_opcode !== 16'd0) begin n_bad++; $display("FAIL reset_opcode: got %0d want 0", ins_opcode); end
        n_cmp++; if (ins_operand !== 16'd0) begin n_bad++; $display("FAIL reset_operand: got %0d want 0", ins_operand); end
        n_cmp++; if (ins_has_operand !== 1'b0) begin n_bad++; $display("FAIL reset_has_operand: got %0b want 0", ins_has_operand); end
        n_cmp++; if (ins_pc !== 16'd0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", ins_pc); end
    endtask

    task automatic test_basic_fetch();
        rst = 1'b0;
        n_cmp++; if (iram_addr !== 16'd0) begin n_bad++; $display("FAIL first_addr: got %0d want 0", iram_addr); end
        wait_valid(n);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL basic_latency1: got %0d want 2", n); end
        n_cmp++; if (ins_opcode !== 16'd35) begin n_bad++; $display("FAIL basic_opcode1: got %0d want 35", ins_opcode); end
        n_cmp++; if (ins_pc !== 16'd0) begin n_bad++; $display("FAIL basic_pc1: got %0d want 0", ins_pc); end
        n_cmp++; if (ins_has_operand !== 1'b0) begin n_bad++; $display("FAIL basic_has1: got %0b want 0", ins_has_operand); end
        n_cmp++; if (ins_operand !== 16'd0) begin n_bad++; $display("FAIL basic_operand1: got %0d want 0", ins_operand); end
        step();  // handshake -> FETCH at pc 1
        n_cmp++; if ({ins_valid, iram_addr} !== {1'b0, 16'd1}) begin n_bad++; $display("FAIL basic_fetch2: got valid=%0b addr=%0d want 0/1", ins_valid, iram_addr); end
        step();  // CAPT_OP sees STAC, looks ahead for its operand
        n_cmp++; if (iram_addr !== 16'd2) begin n_bad++; $display("FAIL basic_lookahead: got %0d want 2", iram_addr); end
        step();  // CAPT_ARG
        n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL basic_capt_arg_valid: got %0b want 0", ins_valid); end
        step();  // VALID
        n_cmp++; if (ins_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid2: got %0b want 1", ins_valid); end
        n_cmp++; if (ins_opcode !== 16'd7) begin n_bad++; $display("FAIL basic_opcode2: got %0d want 7", ins_opcode); end
        n_cmp++; if (ins_operand !== 16'd6) begin n_bad++; $display("FAIL basic_operand2: got %0d want 6", ins_operand); end
        n_cmp++; if (ins_pc !== 16'd1) begin n_bad++; $display("FAIL basic_pc2: got %0d want 1", ins_pc); end
        n_cmp++; if (ins_has_operand !== 1'b1) begin n_bad++; $display("FAIL basic_has2: got %0b want 1", ins_has_operand); end
        ins_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({ins_valid, ins_opcode, ins_operand, ins_pc, ins_has_operand, iram_addr} !==
                {1'b1, 16'd7, 16'd6, 16'd1, 1'b1, 16'd2}) begin
                n_bad++;
                $display("FAIL backpressure_hold cycle %0d: got v=%0b op=%0d arg=%0d pc=%0d has=%0b addr=%0d want 1/7/6/1/1/2",
                         i, ins_valid, ins_opcode, ins_operand, ins_pc, ins_has_operand, iram_addr);
            end
        end
        ins_ready = 1'b1;
        step();
        n_cmp++; if ({ins_valid, iram_addr} !== {1'b0, 16'd3}) begin n_bad++; $display("FAIL backpressure_advance: got valid=%0b addr=%0d want 0/3", ins_valid, iram_addr); end
    endtask

    task automatic test_back_to_back();
        wait_valid(n);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 2", n); end
        n_cmp++; if ({ins_opcode, ins_pc, ins_has_operand} !== {16'd17, 16'd3, 1'b0}) begin n_bad++; $display("FAIL b2b_instr1: got op=%0d pc=%0d has=%0b want 17/3/0", ins_opcode, ins_pc, ins_has_operand); end
        wait_valid(n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 4", n); end
        n_cmp++; if ({ins_opcode, ins_operand, ins_pc} !== {16'd19, 16'hBEEF, 16'd4}) begin n_bad++; $display("FAIL b2b_instr2: got op=%0d arg=%h pc=%0d want 19/beef/4", ins_opcode, ins_operand, ins_pc); end
    endtask

    task automatic test_redirect();
        ins_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'd67;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if ({ins_valid, iram_addr} !== {1'b0, 16'd67}) begin n_bad++; $display("FAIL redirect67: got valid=%0b addr=%0d want 0/67", ins_valid, iram_addr); end
        step();  // CAPT_OP of LDB
        n_cmp++; if (iram_addr !== 16'd68) begin n_bad++; $display("FAIL redirect_lookahead: got %0d want 68", iram_addr); end
        step();  // CAPT_ARG: redirect away now
        redirect_valid = 1'b1; redirect_addr = 16'd14; ins_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if ({ins_valid, iram_addr} !== {1'b0, 16'd14}) begin n_bad++; $display("FAIL redirect14: got valid=%0b addr=%0d want 0/14", ins_valid, iram_addr); end
        wait_valid(n);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL redirect_latency: got %0d want 2", n); end
        n_cmp++; if ({ins_pc, ins_opcode} !== {16'd14, 16'd33}) begin n_bad++; $display("FAIL redirect_target: got pc=%0d op=%0d want 14/33", ins_pc, ins_opcode); end
        // Redirect coinciding with a handshake: target wins over pc+1.
        redirect_valid = 1'b1; redirect_addr = 16'd98;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if ({ins_valid, iram_addr} !== {1'b0, 16'd98}) begin n_bad++; $display("FAIL redirect_with_handshake: got valid=%0b addr=%0d want 0/98", ins_valid, iram_addr); end
    endtask

    task automatic test_halt();
        wait_valid(n);
        n_cmp++; if ({ins_opcode, ins_pc} !== {16'd51, 16'd98}) begin n_bad++; $display("FAIL halt_endop: got op=%0d pc=%0d want 51/98", ins_opcode, ins_pc); end
        step();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({halted, ins_valid, iram_addr} !== {1'b1, 1'b0, 16'd99}) begin
                n_bad++;
                $display("FAIL halt_hold cycle %0d: got halted=%0b valid=%0b addr=%0d want 1/0/99", i, halted, ins_valid, iram_addr);
            end
            step();
        end
        redirect_valid = 1'b1; redirect_addr = 16'd0;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if ({halted, ins_valid, iram_addr} !== {1'b0, 1'b0, 16'd0}) begin n_bad++; $display("FAIL halt_resume: got halted=%0b valid=%0b addr=%0d want 0/0/0", halted, ins_valid, iram_addr); end
        wait_valid(n);
        n_cmp++; if ({ins_opcode, ins_pc} !== {16'd35, 16'd0}) begin n_bad++; $display("FAIL halt_refetch: got op=%0d pc=%0d want 35/0", ins_opcode, ins_pc); end
`ifdef IFETCH_COUNT_EN
        n_cmp++; if (ins_count !== hs_count) begin n_bad++; $display("FAIL count_running: got %0d want %0d", ins_count, hs_count); end
`endif
    endtask

    task automatic test_reset_mid_operand();
        redirect_valid = 1'b1; redirect_addr = 16'd4;
        step();
        redirect_valid = 1'b0;
        step();  // CAPT_OP of LDC
        n_cmp++; if (iram_addr !== 16'd5) begin n_bad++; $display("FAIL midop_lookahead: got %0d want 5", iram_addr); end
        step();  // CAPT_ARG: reset together with a redirect
        rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'd67;
        step();
        n_cmp++;
        if ({ins_valid, halted, ins_opcode, ins_operand, ins_has_operand, ins_pc, iram_addr} !==
            {1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL midop_reset: got v=%0b h=%0b op=%0d arg=%0d has=%0b pc=%0d addr=%0d want all 0",
                     ins_valid, halted, ins_opcode, ins_operand, ins_has_operand, ins_pc, iram_addr);
        end
`ifdef IFETCH_COUNT_EN
        n_cmp++; if (ins_count !== 16'd0) begin n_bad++; $display("FAIL count_reset: got %0d want 0", ins_count); end
`endif
        rst = 1'b0; redirect_valid = 1'b0;
        wait_valid(n);
        n_cmp++; if ({ins_opcode, ins_pc} !== {16'd35, 16'd0}) begin n_bad++; $display("FAIL midop_restart: got op=%0d pc=%0d want 35/0", ins_opcode, ins_pc); end
`ifdef IFETCH_COUNT_EN
        step();
        n_cmp++; if (ins_count !== 16'd1) begin n_bad++; $display("FAIL count_after_reset: got %0d want 1", ins_count); end
`endif
    endtask

    task automatic test_wrap();
        rst_w = 1'b0;
        n_cmp++; if (iram_addr_w !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_first_addr: got %h want ffff", iram_addr_w); end
        step();  // CAPT_OP: operand address wraps to 0
        n_cmp++; if (iram_addr_w !== 16'h0000) begin n_bad++; $display("FAIL wrap_operand_addr: got %h want 0000", iram_addr_w); end
        step(); step();
        n_cmp++;
        if ({ins_valid_w, ins_opcode_w, ins_operand_w, ins_pc_w} !== {1'b1, 16'd5, 16'd4, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL wrap_instr: got v=%0b op=%0d arg=%0d pc=%h want 1/5/4/ffff", ins_valid_w, ins_opcode_w, ins_operand_w, ins_pc_w);
        end
        step();
        n_cmp++; if (iram_addr_w !== 16'd1) begin n_bad++; $display("FAIL wrap_next_addr: got %0d want 1", iram_addr_w); end
        step(); step();
        n_cmp++; if ({ins_valid_w, ins_pc_w, ins_opcode_w} !== {1'b1, 16'd1, 16'd51}) begin n_bad++; $display("FAIL wrap_next_instr: got v=%0b pc=%0d op=%0d want 1/1/51", ins_valid_w, ins_pc_w, ins_opcode_w); end
        step();
        n_cmp++; if ({halted_w, ins_valid_w} !== {1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_halt: got halted=%0b valid=%0b want 1/0", halted_w, ins_valid_w); end
`ifdef IFETCH_COUNT_EN
        n_cmp++; if (ins_count_w !== 16'd2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", ins_count_w); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'd0;
        ram[0]  = 16'd35;
        ram[1]  = 16'd7;
        ram[2]  = 16'd6;
        ram[3]  = 16'd17;
        ram[4]  = 16'd19;
        ram[5]  = 16'hBEEF;
        ram[14] = 16'd33;
        ram[67] = 16'd14;
        ram[68] = 16'h5555;
        ram[98] = 16'd51;
        rst_w = 1'b1; ins_ready_w = 1'b1; redirect_valid_w = 1'b0; redirect_addr_w = 16'd0;

        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_back_to_back();
        test_redirect();
        test_halt();
        test_reset_mid_operand();
        test_wrap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
